// File: rtl/gpio_in_filter.sv
// Per-pin input conditioner: synchronise each pad, debounce it with a
// consecutive-cycle qualifier, and raise sticky edge flags plus an interrupt.
module gpio_in_filter #(
  parameter int IO_WIDTH     = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST_N,
  input  logic [IO_WIDTH-1:0] PAD_IN,
  input  logic [IO_WIDTH-1:0] RISE_EN,
  input  logic [IO_WIDTH-1:0] FALL_EN,
  input  logic [IO_WIDTH-1:0] EVENT_CLR,
  output logic [IO_WIDTH-1:0] IO_IN,
  output logic [IO_WIDTH-1:0] EVENT,
  output logic                IRQ
);

  localparam int              CW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_e;

  logic [IO_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [IO_WIDTH-1:0] s;
  state_e              state_q [IO_WIDTH];
  logic [CW-1:0]       cnt_q   [IO_WIDTH];
  logic [IO_WIDTH-1:0] level_q;
  logic [IO_WIDTH-1:0] accept;
  logic [IO_WIDTH-1:0] event_d;
  logic [IO_WIDTH-1:0] event_q;
  logic                irq_q;

  // NOTE: sequential state uses <= so every flop samples the pre-edge value;
  // with = the chain would collapse into a single stage.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= PAD_IN;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // A bit accepts its new level when the differing input has persisted
  // DEBOUNCE_CNT samples; with a count of one that is the very first sample.
  // NOTE: accept gets a default before the loop so no path leaves it unassigned
  // (otherwise a latch is inferred).
  always_comb begin
    accept = '0;
    for (int i = 0; i < IO_WIDTH; i++) begin
      if (s[i] != level_q[i]) begin
        case (state_q[i])
          IDLE:    accept[i] = (DEBOUNCE_CNT == 1);
          QUAL:    accept[i] = (cnt_q[i] == CNT_LAST);
          default: accept[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      level_q <= '0;
      for (int i = 0; i < IO_WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < IO_WIDTH; i++) begin
        case (state_q[i])
          IDLE: begin
            if (s[i] != level_q[i]) begin
              if (accept[i]) begin
                level_q[i] <= s[i];
              end else begin
                state_q[i] <= QUAL;
                cnt_q[i]   <= CNT_ONE;
              end
            end
          end
          QUAL: begin
            if (s[i] == level_q[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else if (accept[i]) begin
              level_q[i] <= s[i];
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  // An accepted transition toward s is a rise when s is 1; a new set beats
  // a simultaneous clear.
  assign event_d = (event_q & ~EVENT_CLR)
                 | (accept & ((s & RISE_EN) | (~s & FALL_EN)));

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      event_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= event_d;
      irq_q   <= |event_q;
    end
  end

  assign IO_IN = level_q;
  assign EVENT = event_q;
  assign IRQ   = irq_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: default instance plus a
// DEBOUNCE_CNT=1 / SYNC_STAGES=3 instance for the parameter corner.
module tb_gpio_in_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pad, rise_en, fall_en, evt_clr;
  logic [7:0] io_in, evt;
  logic       irq;
  logic [7:0] pad2, rise_en2, fall_en2, evt_clr2;
  logic [7:0] io_in2, evt2;
  logic       irq2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_in_filter dut (
    .BUS_CLK  (clk),
    .BUS_RST_N(rst_n),
    .PAD_IN   (pad),
    .RISE_EN  (rise_en),
    .FALL_EN  (fall_en),
    .EVENT_CLR(evt_clr),
    .IO_IN    (io_in),
    .EVENT    (evt),
    .IRQ      (irq)
  );

  gpio_in_filter #(.IO_WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CNT(1)) dut_fast (
    .BUS_CLK  (clk),
    .BUS_RST_N(rst_n),
    .PAD_IN   (pad2),
    .RISE_EN  (rise_en2),
    .FALL_EN  (fall_en2),
    .EVENT_CLR(evt_clr2),
    .IO_IN    (io_in2),
    .EVENT    (evt2),
    .IRQ      (irq2)
  );

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    evt_clr = 8'hFF;
    step(1);
    evt_clr = 8'h00;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pad = '0; rise_en = '0; fall_en = '0; evt_clr = '0;
    pad2 = '0; rise_en2 = 8'h01; fall_en2 = '0; evt_clr2 = '0;
    step(3);
    total++; if (io_in !== 8'h00) begin bad++; $display("FAIL reset_io_in got=%h exp=00", io_in); end
    total++; if (evt !== 8'h00) begin bad++; $display("FAIL reset_event got=%h exp=00", evt); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (io_in2 !== 8'h00) begin bad++; $display("FAIL reset_io_in_fast got=%h exp=00", io_in2); end
    rst_n = 1'b1;
    step(4);
  endtask

  task automatic test_basic();
    rise_en = 8'h01; fall_en = 8'h00;
    pad[0] = 1'b1;
    step(17);
    total++; if (io_in[0] !== 1'b0) begin bad++; $display("FAIL basic_rise_early got=%b exp=0", io_in[0]); end
    step(1);
    total++; if (io_in[0] !== 1'b1) begin bad++; $display("FAIL basic_rise_io_in got=%b exp=1", io_in[0]); end
    total++; if (evt !== 8'h01) begin bad++; $display("FAIL basic_rise_event got=%h exp=01", evt); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_lag got=%b exp=0", irq); end
    step(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%b exp=1", irq); end
    pad[0] = 1'b0;
    step(17);
    total++; if (io_in[0] !== 1'b1) begin bad++; $display("FAIL basic_fall_early got=%b exp=1", io_in[0]); end
    step(1);
    total++; if (io_in[0] !== 1'b0) begin bad++; $display("FAIL basic_fall_io_in got=%b exp=0", io_in[0]); end
    total++; if (evt !== 8'h01) begin bad++; $display("FAIL basic_fall_event got=%h exp=01", evt); end
    evt_clr = 8'h01;
    step(1);
    evt_clr = 8'h00;
    total++; if (evt !== 8'h00) begin bad++; $display("FAIL basic_clr_event got=%h exp=00", evt); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_clr_irq_lag got=%b exp=1", irq); end
    step(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL basic_clr_irq got=%b exp=0", irq); end
  endtask

  task automatic test_glitch();
    logic seen;
    int   high_cnt;
    rise_en = 8'h08; fall_en = 8'h00;
    seen = 1'b0;
    pad[3] = 1'b1;
    for (int k = 0; k < 15; k++) begin step(1); seen |= io_in[3]; end
    pad[3] = 1'b0;
    for (int k = 0; k < 25; k++) begin step(1); seen |= io_in[3]; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch15_io_in got=%b exp=0", seen); end
    total++; if (evt[3] !== 1'b0) begin bad++; $display("FAIL glitch15_event got=%b exp=0", evt[3]); end
    pad[3] = 1'b1;
    step(16);
    pad[3] = 1'b0;
    step(1);
    total++; if (io_in[3] !== 1'b0) begin bad++; $display("FAIL pulse16_early got=%b exp=0", io_in[3]); end
    step(1);
    total++; if (io_in[3] !== 1'b1) begin bad++; $display("FAIL pulse16_io_in got=%b exp=1", io_in[3]); end
    total++; if (evt[3] !== 1'b1) begin bad++; $display("FAIL pulse16_event got=%b exp=1", evt[3]); end
    high_cnt = 1;
    for (int k = 0; k < 30; k++) begin step(1); if (io_in[3]) high_cnt++; end
    total++; if (high_cnt !== 16) begin bad++; $display("FAIL pulse16_width got=%0d exp=16", high_cnt); end
    clear_all();
  endtask

  task automatic test_bounce();
    rise_en = 8'h02; fall_en = 8'h00;
    pad[1] = 1'b1;
    step(10);
    pad[1] = 1'b0;
    step(2);
    pad[1] = 1'b1;
    step(17);
    total++; if (io_in[1] !== 1'b0) begin bad++; $display("FAIL bounce_early got=%b exp=0", io_in[1]); end
    step(1);
    total++; if (io_in[1] !== 1'b1) begin bad++; $display("FAIL bounce_io_in got=%b exp=1", io_in[1]); end
    total++; if (evt !== 8'h02) begin bad++; $display("FAIL bounce_event got=%h exp=02", evt); end
    clear_all();
  endtask

  task automatic test_collision();
    rise_en = 8'h04; fall_en = 8'h04;
    pad[2] = 1'b1;
    step(18);
    total++; if (evt !== 8'h04) begin bad++; $display("FAIL coll_set got=%h exp=04", evt); end
    step(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_irq_set got=%b exp=1", irq); end
    evt_clr = 8'h04;
    step(1);
    evt_clr = 8'h00;
    total++; if (evt[2] !== 1'b0) begin bad++; $display("FAIL coll_clear got=%b exp=0", evt[2]); end
    step(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL coll_clear_irq got=%b exp=0", irq); end
    pad[2] = 1'b0;
    step(17);
    evt_clr = 8'h04;
    step(1);
    evt_clr = 8'h00;
    total++; if (io_in[2] !== 1'b0) begin bad++; $display("FAIL coll_fall_io_in got=%b exp=0", io_in[2]); end
    total++; if (evt[2] !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b exp=1", evt[2]); end
    step(1);
    total++; if (evt[2] !== 1'b1) begin bad++; $display("FAIL coll_sticky got=%b exp=1", evt[2]); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_irq got=%b exp=1", irq); end
  endtask

  task automatic test_reset_mid_qual();
    rise_en = 8'hFF; fall_en = 8'h00;
    pad = 8'hFF;
    step(10);
    rst_n = 1'b0;
    #1;
    total++; if (io_in !== 8'h00) begin bad++; $display("FAIL rstq_io_in got=%h exp=00", io_in); end
    total++; if (evt !== 8'h00) begin bad++; $display("FAIL rstq_event got=%h exp=00", evt); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rstq_irq got=%b exp=0", irq); end
    step(2);
    rst_n = 1'b1;
    step(17);
    total++; if (io_in !== 8'h00) begin bad++; $display("FAIL rstq_early got=%h exp=00", io_in); end
    step(1);
    total++; if (io_in !== 8'hFF) begin bad++; $display("FAIL rstq_io_in_rel got=%h exp=ff", io_in); end
    total++; if (evt !== 8'hFF) begin bad++; $display("FAIL rstq_event_rel got=%h exp=ff", evt); end
    step(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL rstq_irq_rel got=%b exp=1", irq); end
  endtask

  task automatic test_param_corner();
    pad2[0] = 1'b1;
    step(1);
    pad2[0] = 1'b0;
    step(2);
    total++; if (io_in2[0] !== 1'b0) begin bad++; $display("FAIL fast_early got=%b exp=0", io_in2[0]); end
    step(1);
    total++; if (io_in2[0] !== 1'b1) begin bad++; $display("FAIL fast_io_in got=%b exp=1", io_in2[0]); end
    total++; if (evt2[0] !== 1'b1) begin bad++; $display("FAIL fast_event got=%b exp=1", evt2[0]); end
    step(1);
    total++; if (io_in2[0] !== 1'b0) begin bad++; $display("FAIL fast_width got=%b exp=0", io_in2[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_bounce();
    test_collision();
    test_reset_mid_qual();
    test_param_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
